fir_coef_bank: RTL and testbench

// Coefficient staging stage feeding the time-multiplexed FIR tap chain. Register-map

---
 rtl/fir_coef_bank_if.sv | 29 ++
 rtl/fir_coef_bank.sv | 81 ++++++++
 tb/tb_fir_coef_bank.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_bank_if.sv
// fir_coef_bank_if: register-map write port and coefficient-bank outputs of fir_coef_bank
interface fir_coef_bank_if #(
  parameter int COEF_WIDTH = 18,
  parameter int DSP_NR = 32,
  parameter int TM = 2
);
  localparam int COEFS_NR = DSP_NR * TM;
  localparam int ADDR_WIDTH = $clog2(COEFS_NR);
  logic wr_en;
  logic [ADDR_WIDTH:0] wr_addr;
  logic signed [COEF_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0] coef_nr_in;
  logic update_req;
  logic clear_req;
  logic slot_start;
  logic [COEFS_NR*COEF_WIDTH-1:0] coefs_flat;
  logic [ADDR_WIDTH:0] active_nr;
  logic update_ack;
  logic busy;
  logic wr_err;
  modport slave (
    input wr_en, wr_addr, wr_data, coef_nr_in, update_req, clear_req, slot_start,
    output coefs_flat, active_nr, update_ack, busy, wr_err
  );
  modport master (
    output wr_en, wr_addr, wr_data, coef_nr_in, update_req, clear_req, slot_start,
    input coefs_flat, active_nr, update_ack, busy, wr_err
  );
endinterface

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: shadow/active coefficient banks with slot-aligned atomic commit and sequential clear
module fir_coef_bank #(
  parameter int COEF_WIDTH = 18,
  parameter int DSP_NR = 32,
  parameter int TM = 2
) (
  input logic fir_clk,
  input logic fir_rst,
  fir_coef_bank_if.slave bus
);
  localparam int COEFS_NR = DSP_NR * TM;
  localparam int ADDR_WIDTH = $clog2(COEFS_NR);
  localparam logic [ADDR_WIDTH:0] NR_MAX = (ADDR_WIDTH+1)'(COEFS_NR);
  typedef enum logic [1:0] {IDLE, CLEAR, ARMED} state_t;
  state_t state, state_n;
  logic pending, pending_n;
  logic [ADDR_WIDTH-1:0] idx;
  logic signed [COEF_WIDTH-1:0] shadow [COEFS_NR];
  logic signed [COEF_WIDTH-1:0] active [COEFS_NR];
  logic [ADDR_WIDTH:0] nr_c, active_nr;
  logic update_ack, wr_err, commit, last, wr_ok, pend_any;
  assign last = idx == ADDR_WIDTH'(COEFS_NR - 1);
  assign commit = state == ARMED && bus.slot_start;
  assign wr_ok = bus.wr_en && bus.wr_addr < NR_MAX && state != CLEAR;
  assign nr_c = bus.coef_nr_in > NR_MAX ? NR_MAX : bus.coef_nr_in;
  assign pend_any = pending | bus.update_req;
  assign bus.busy = state != IDLE;
  assign bus.active_nr = active_nr;
  assign bus.update_ack = update_ack;
  assign bus.wr_err = wr_err;
  for (genvar k = 0; k < COEFS_NR; k++) begin : g_flat
    assign bus.coefs_flat[k*COEF_WIDTH +: COEF_WIDTH] = active[k];
  end
  // state register; reset aborts any clear or armed commit in flight
  always_ff @(posedge fir_clk) begin
    if (fir_rst) begin
      state <= IDLE;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pending_n;
    end
  end
  // next state: clear wins over update, an update seen during clear is remembered and armed afterwards
  always_comb begin
    state_n = IDLE;
    pending_n = pending;
    if (state == IDLE) begin
      state_n = bus.clear_req ? CLEAR : bus.update_req ? ARMED : IDLE;
      pending_n = bus.clear_req && bus.update_req;
    end else if (state == CLEAR) begin
      state_n = last ? (pend_any ? ARMED : IDLE) : CLEAR;
      pending_n = last ? 1'b0 : pend_any;
    end else if (state == ARMED) begin
      state_n = bus.slot_start ? IDLE : ARMED;
    end
  end
  // banks: commit reads the pre-edge shadow, so a write on the commit edge lands in shadow only
  always_ff @(posedge fir_clk) begin
    if (fir_rst) begin
      for (int k = 0; k < COEFS_NR; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      active_nr <= '0;
      update_ack <= 1'b0;
      wr_err <= 1'b0;
      idx <= '0;
    end else begin
      update_ack <= commit;
      wr_err <= wr_err | (bus.wr_en && !wr_ok);
      idx <= state == CLEAR ? idx + 1'b1 : '0;
      if (commit) begin
        for (int k = 0; k < COEFS_NR; k++) active[k] <= (ADDR_WIDTH+1)'(k) < nr_c ? shadow[k] : '0;
        active_nr <= nr_c;
      end
      if (state == CLEAR) shadow[idx] <= '0;
      if (wr_ok) shadow[bus.wr_addr[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_fir_coef_bank.sv
// tb_fir_coef_bank: randomized scoreboard bench for fir_coef_bank against an array-based bank model
module tb_fir_coef_bank;
  localparam int W = 18;
  localparam int N = 64;
  localparam int AW = 6;
  typedef struct {
    logic [N*W-1:0] flat;
    int nr;
  } exp_t;
  logic fir_clk = 1'b0;
  logic fir_rst = 1'b1;
  fir_coef_bank_if bus ();
  fir_coef_bank dut (.fir_clk(fir_clk), .fir_rst(fir_rst), .bus(bus));
  always #5 fir_clk = ~fir_clk;
  exp_t q[$];
  logic signed [W-1:0] sh_m [N];
  logic [N*W-1:0] cur_flat = '0;
  int cur_nr = 0;
  int mode = 0;
  int clr_left = 0;
  bit pend_m = 0;
  bit err_m = 0;
  int n_chk = 0;
  int n_pass = 0;
  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction
  function automatic void chk_flat(logic [N*W-1:0] act, logic [N*W-1:0] exp);
    n_chk++;
    if (act == exp) n_pass++;
    else
      for (int k = 0; k < N; k++)
        if (act[k*W +: W] != exp[k*W +: W]) begin
          $display("FAIL coefs_flat coef %0d: got %0d expected %0d", k, $signed(act[k*W +: W]), $signed(exp[k*W +: W]));
          break;
        end
  endfunction
  function automatic exp_t commit_exp(int nr_in);
    exp_t e;
    e.nr = nr_in > N ? N : nr_in;
    e.flat = '0;
    for (int k = 0; k < e.nr; k++) e.flat[k*W +: W] = sh_m[k];
    return e;
  endfunction
  // one clock edge: model follows the inputs held across it, then pulses drop
  task automatic step();
    exp_t e;
    bit have = 0;
    @(posedge fir_clk);
    if (mode == 2 && bus.slot_start) begin
      e = commit_exp(int'(bus.coef_nr_in));
      have = 1;
    end
    if (mode == 1) sh_m[N - clr_left] = '0;
    if (bus.wr_en) begin
      if (int'(bus.wr_addr) < N && mode != 1) sh_m[int'(bus.wr_addr)] = bus.wr_data;
      else err_m = 1;
    end
    if (mode == 0) begin
      if (bus.clear_req) begin
        mode = 1;
        clr_left = N;
        pend_m = bus.update_req;
      end else if (bus.update_req) mode = 2;
    end else if (mode == 1) begin
      pend_m = pend_m | bus.update_req;
      clr_left--;
      if (clr_left == 0) begin
        mode = pend_m ? 2 : 0;
        pend_m = 0;
      end
    end else if (bus.slot_start) mode = 0;
    if (have) q.push_back(e);
    #1;
    bus.wr_en = 0;
    bus.update_req = 0;
    bus.clear_req = 0;
    bus.slot_start = 0;
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic wr(int a, logic signed [W-1:0] d);
    bus.wr_en = 1;
    bus.wr_addr = 7'(a);
    bus.wr_data = d;
    step();
  endtask
  task automatic do_reset();
    fir_rst = 1;
    @(posedge fir_clk);
    #1;
    fir_rst = 0;
    for (int k = 0; k < N; k++) sh_m[k] = '0;
    cur_flat = '0;
    cur_nr = 0;
    mode = 0;
    pend_m = 0;
    err_m = 0;
    q.delete();
  endtask
  task automatic fill_random();
    for (int k = 0; k < N; k++) wr(k, W'($urandom));
  endtask
  // scoreboard monitor: every cycle the outputs must match the last committed bank and the model status
  always @(negedge fir_clk) begin
    exp_t e;
    if (!fir_rst) begin
      chk("update_ack", bus.update_ack, q.size() != 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        cur_flat = e.flat;
        cur_nr = e.nr;
      end
      chk_flat(bus.coefs_flat, cur_flat);
      chk("active_nr", bus.active_nr, cur_nr);
      chk("busy", bus.busy, mode != 0);
      chk("wr_err", bus.wr_err, err_m);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic signed [W-1:0] old5, new5;
    bus.wr_en = 0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.coef_nr_in = 7'd64;
    bus.update_req = 0;
    bus.clear_req = 0;
    bus.slot_start = 0;
    do_reset();
    idle(2);
    chk("reset coefs", bus.coefs_flat == '0, 1);
    chk("reset active_nr", bus.active_nr, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset wr_err", bus.wr_err, 0);
    for (int k = 0; k < N; k++) wr(k, W'(k * 3));
    bus.update_req = 1;
    step();
    idle(5);
    chk("coef10 before slot", $signed(bus.coefs_flat[10*W +: W]), 0);
    bus.slot_start = 1;
    step();
    chk("ack pulse", bus.update_ack, 1);
    chk("coef10", $signed(bus.coefs_flat[10*W +: W]), 30);
    chk("active_nr 64", bus.active_nr, 64);
    step();
    chk("ack single", bus.update_ack, 0);
    bus.coef_nr_in = 7'd40;
    bus.update_req = 1;
    step();
    idle(5);
    bus.slot_start = 1;
    step();
    chk("coef39", $signed(bus.coefs_flat[39*W +: W]), 117);
    chk("coef45 zero", $signed(bus.coefs_flat[45*W +: W]), 0);
    chk("active_nr 40", bus.active_nr, 40);
    bus.coef_nr_in = 7'd100;
    bus.update_req = 1;
    step();
    bus.slot_start = 1;
    step();
    chk("active_nr clamp", bus.active_nr, 64);
    chk("coef63", $signed(bus.coefs_flat[63*W +: W]), 189);
    wr(64, 18'sd123);
    chk("wr_err set", bus.wr_err, 1);
    bus.update_req = 1;
    step();
    bus.slot_start = 1;
    step();
    chk("coef0 after bad write", $signed(bus.coefs_flat[0 +: W]), 0);
    idle(3);
    chk("wr_err sticky", bus.wr_err, 1);
    do_reset();
    fill_random();
    bus.clear_req = 1;
    bus.update_req = 1;
    step();
    for (int i = 0; i < N; i++) begin
      chk("busy in clear", bus.busy, 1);
      if (i == 10) begin
        bus.wr_en = 1;
        bus.wr_addr = 7'd3;
        bus.wr_data = 18'sd77;
      end
      step();
    end
    chk("armed after clear", bus.busy, 1);
    chk("wr_err clear write", bus.wr_err, 1);
    bus.slot_start = 1;
    step();
    chk("cleared bank", bus.coefs_flat == '0, 1);
    fill_random();
    bus.clear_req = 1;
    step();
    for (int i = 0; i < N; i++) begin
      if (i == 20) bus.update_req = 1;
      step();
    end
    chk("pending arms", bus.busy, 1);
    bus.slot_start = 1;
    step();
    fill_random();
    bus.clear_req = 1;
    step();
    idle(N);
    chk("clear to idle", bus.busy, 0);
    do_reset();
    fill_random();
    bus.update_req = 1;
    step();
    idle(2);
    do_reset();
    bus.slot_start = 1;
    step();
    chk("reset aborts armed", bus.update_ack, 0);
    chk("bank zero after abort", bus.coefs_flat == '0, 1);
    fill_random();
    old5 = sh_m[5];
    new5 = ~old5;
    bus.coef_nr_in = 7'd64;
    bus.update_req = 1;
    step();
    bus.slot_start = 1;
    bus.wr_en = 1;
    bus.wr_addr = 7'd5;
    bus.wr_data = new5;
    step();
    chk("commit uses old coef5", $signed(bus.coefs_flat[5*W +: W]), old5);
    bus.update_req = 1;
    step();
    bus.slot_start = 1;
    step();
    chk("shadow holds new coef5", $signed(bus.coefs_flat[5*W +: W]), new5);
    for (int it = 0; it < 30; it++) begin
      if (it == 15) do_reset();
      repeat ($urandom_range(1, 12)) wr($urandom_range(0, 80), W'($urandom));
      if ($urandom_range(0, 3) == 0) bus.slot_start = 1;
      step();
      bus.coef_nr_in = 7'($urandom_range(0, 127));
      bus.update_req = 1;
      bus.clear_req = $urandom_range(0, 4) == 0;
      step();
      if (bus.busy) repeat (N + 2) if (mode == 1) step();
      repeat ($urandom_range(0, 6)) begin
        bus.update_req = $urandom_range(0, 1);
        bus.clear_req = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 1)) begin
          bus.wr_en = 1;
          bus.wr_addr = 7'($urandom_range(0, 70));
          bus.wr_data = W'($urandom);
        end
        step();
      end
      bus.slot_start = 1;
      if ($urandom_range(0, 1)) begin
        bus.wr_en = 1;
        bus.wr_addr = 7'($urandom_range(0, 63));
        bus.wr_data = W'($urandom);
      end
      step();
      idle(1);
    end
    idle(2);
    chk("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
